// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters using round-robin
//   arbitration. Each requester hands over one op through a valid/ready
//   handshake. The op and operands are registered and driven to the ALU, the
//   result is sampled after LAT cycles, and it is returned on a response
//   channel that is held until the consumer accepts it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/_ready       request handshake (ready only in IDLE, granted side)
//   req{0,1}_op/_a/_b           request op code and operands
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/_data/_zero/_err     response owner, result, zero flag, illegal-op flag
//   alu_a/alu_b/alu_op          registered drive to the ALU
//   alu_out/alu_zero            ALU result and zero flag
module alu_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 3,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]     CNT_INIT = 4'(LAT - 1);
  localparam logic [OPW-1:0] OP_MAX   = OPW'(5);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic gnt0, gnt1;
  logic op_illegal;

  // Grant selection. Gated by rst_n so both readies read 0 while reset is
  // asserted, even though the state register already sits in IDLE.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE && rst_n) begin
      if (!rr_q) begin
        if (req0_valid)      gnt0 = 1'b1;
        else if (req1_valid) gnt1 = 1'b1;
      end else begin
        if (req1_valid)      gnt1 = 1'b1;
        else if (req0_valid) gnt0 = 1'b1;
      end
    end
  end

  assign op_illegal = (op_q > OP_MAX);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          op_d    = gnt1 ? req1_op : req0_op;
          a_d     = gnt1 ? req1_a  : req0_a;
          b_d     = gnt1 ? req1_b  : req0_b;
          cnt_d   = CNT_INIT;
          rr_d    = ~gnt1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          // Illegal ops still reach the ALU; only the result is discarded.
          rsp_data_d = op_illegal ? '0 : alu_out;
          rsp_zero_d = alu_zero;
          rsp_err_d  = op_illegal;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;

endmodule
